// File: rtl/pwr_seq_pkg.sv
// Shared types and defaults for the power sequencing controller.
package pwr_seq_pkg;

  localparam int NUM_DOM     = 4;
  localparam int DOM_W       = 2;
  localparam int ISO_DLY_DEF = 4;
  localparam int PSW_DLY_DEF = 8;
  localparam int TIMEOUT_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISO_SET = 3'd1,
    ST_PSW_CLR = 3'd2,
    ST_PSW_SET = 3'd3,
    ST_ISO_CLR = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic logic [NUM_DOM-1:0] dom_mask(input logic [DOM_W-1:0] dom);
    logic [NUM_DOM-1:0] one;
    one = {{(NUM_DOM-1){1'b0}}, 1'b1};
    return one << dom;
  endfunction

endpackage

// File: rtl/pwr_dly_cnt.sv
// Loadable saturating down-counter; expired_o is high while the count is zero.
module pwr_dly_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  // Count register: load has priority, otherwise decrement down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o     = cnt_q;
  assign expired_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power sequencing controller: isolation, switch and acknowledge handshake for
// one domain transition at a time, with acknowledge timeout.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int                 ISO_DLY  = ISO_DLY_DEF,
  parameter int                 PSW_DLY  = PSW_DLY_DEF,
  parameter int                 TIMEOUT  = TIMEOUT_DEF,
  parameter logic [NUM_DOM-1:0] RESET_ON = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DOM_W-1:0]   req_dom,
  input  logic               req_on,
  input  logic [NUM_DOM-1:0] psw_ack,
  output logic [NUM_DOM-1:0] iso_ctrl,
  output logic [NUM_DOM-1:0] psw_ctrl,
  output logic [NUM_DOM-1:0] dom_on,
  output logic               done,
  output logic               err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Outputs follow the state by one edge, so hold loads are one less than the hold.
  localparam logic [CW-1:0] ISO_LD   = CW'(ISO_DLY - 1);
  localparam logic [CW-1:0] PSW_LD   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MIN_LEFT = CW'(TIMEOUT - PSW_DLY);

  state_e               state_q, state_d;
  logic [DOM_W-1:0]     dom_q, dom_d;
  logic                 on_q, on_d;
  logic                 tmo_q, tmo_d;
  logic [NUM_DOM-1:0]   iso_q, iso_d;
  logic [NUM_DOM-1:0]   psw_q, psw_d;
  logic [NUM_DOM-1:0]   dom_on_q, dom_on_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;

  logic                 cnt_load;
  logic [CW-1:0]        cnt_ld_val;
  logic [CW-1:0]        cnt_val;
  logic                 cnt_expired;
  logic [NUM_DOM-1:0]   mask;
  logic                 ack_ok;
  logic                 min_ok;

  pwr_dly_cnt #(.W(CW)) u_dly_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_ld_val),
    .cnt_o      (cnt_val),
    .expired_o  (cnt_expired)
  );

  assign mask   = dom_mask(dom_q);
  // Compare against the target level so the settle check never sees the pre-change switch value.
  assign ack_ok = (psw_ack[dom_q] == on_q);
  assign min_ok = (cnt_val <= MIN_LEFT);

  // Next state, request capture and next values of all registered outputs.
  always_comb begin
    state_d    = state_q;
    dom_d      = dom_q;
    on_d       = on_q;
    tmo_d      = tmo_q;
    iso_d      = iso_q;
    psw_d      = psw_q;
    dom_on_d   = dom_on_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cnt_load   = 1'b0;
    cnt_ld_val = {CW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          dom_d = req_dom;
          on_d  = req_on;
          tmo_d = 1'b0;
          if (req_on == dom_on_q[req_dom]) begin
            state_d = ST_DONE;
          end else if (req_on) begin
            state_d    = ST_PSW_SET;
            cnt_load   = 1'b1;
            cnt_ld_val = PSW_LD;
          end else begin
            state_d    = ST_ISO_SET;
            cnt_load   = 1'b1;
            cnt_ld_val = ISO_LD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISO_SET: begin
        iso_d = iso_q | mask;
        if (cnt_expired) begin
          state_d    = ST_PSW_CLR;
          cnt_load   = 1'b1;
          cnt_ld_val = PSW_LD;
        end else begin
          state_d = ST_ISO_SET;
        end
      end
      ST_PSW_CLR: begin
        psw_d = psw_q & ~mask;
        if (min_ok && ack_ok) begin
          state_d = ST_DONE;
        end else if (cnt_expired) begin
          state_d = ST_DONE;
          tmo_d   = 1'b1;
        end else begin
          state_d = ST_PSW_CLR;
        end
      end
      ST_PSW_SET: begin
        psw_d = psw_q | mask;
        if (min_ok && ack_ok) begin
          state_d    = ST_ISO_CLR;
          cnt_load   = 1'b1;
          cnt_ld_val = ISO_LD;
        end else if (cnt_expired) begin
          state_d = ST_DONE;
          tmo_d   = 1'b1;
        end else begin
          state_d = ST_PSW_SET;
        end
      end
      ST_ISO_CLR: begin
        iso_d = iso_q & ~mask;
        if (cnt_expired) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISO_CLR;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        err_d   = tmo_q;
        state_d = ST_IDLE;
        // A failed switch leaves the domain off and isolated.
        if (tmo_q) begin
          psw_d    = psw_q & ~mask;
          dom_on_d = dom_on_q & ~mask;
        end else if (on_q) begin
          dom_on_d = dom_on_q | mask;
        end else begin
          dom_on_d = dom_on_q & ~mask;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dom_q    <= {DOM_W{1'b0}};
      on_q     <= 1'b0;
      tmo_q    <= 1'b0;
      iso_q    <= ~RESET_ON;
      psw_q    <= RESET_ON;
      dom_on_q <= RESET_ON;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      dom_q    <= dom_d;
      on_q     <= on_d;
      tmo_q    <= tmo_d;
      iso_q    <= iso_d;
      psw_q    <= psw_d;
      dom_on_q <= dom_on_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign iso_ctrl  = iso_q;
  assign psw_ctrl  = psw_q;
  assign dom_on    = dom_on_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Self-checking bench for pwr_seq_ctrl: timeline reference model plus a switch model with lagged acknowledge.
module tb_pwr_seq_ctrl;

  localparam int I = 4;
  localparam int P = 8;
  localparam int T = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_on = 1'b0;
  logic [1:0] req_dom = 2'd0;
  logic [3:0] psw_ack = 4'hF;
  logic       req_ready, done, err;
  logic [3:0] iso_ctrl, psw_ctrl, dom_on;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwr_seq_ctrl #(.ISO_DLY(I), .PSW_DLY(P), .TIMEOUT(T), .RESET_ON(4'hF)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dom   (req_dom),
    .req_on    (req_on),
    .psw_ack   (psw_ack),
    .iso_ctrl  (iso_ctrl),
    .psw_ctrl  (psw_ctrl),
    .dom_on    (dom_on),
    .done      (done),
    .err       (err)
  );

  // Current request as a timeline: event offsets from the acceptance edge.
  logic       r_active = 1'b0;
  logic [1:0] r_d = 2'd0;
  logic       r_on = 1'b0, r_noop = 1'b0, r_tmo = 1'b0, r_stuck = 1'b0;
  int         r_s = 0, r_ciso = 0, r_cd = 0;
  logic [3:0] b_iso = 4'h0, b_psw = 4'hF, b_on = 4'hF;
  int         c_rel = 0;
  int         g_lag = 1;
  logic       chk_en = 1'b0;
  logic [3:0] hist [0:15];

  // {ready, err, done, dom_on, psw_ctrl, iso_ctrl} expected c cycles after acceptance
  function automatic logic [14:0] exp_at(input int c);
    logic [3:0] iso, psw, on;
    logic       dn;
    iso = b_iso; psw = b_psw; on = b_on;
    if (!r_active) return {1'b1, 1'b0, 1'b0, on, psw, iso};
    if (!r_noop) begin
      if (!r_on) begin
        if (c >= 1) iso[r_d] = 1'b1;
        if (c >= r_s) psw[r_d] = 1'b0;
      end else begin
        if (c >= 1) psw[r_d] = 1'b1;
        if (r_tmo && c >= r_cd) psw[r_d] = 1'b0;
        if (!r_tmo && c >= r_ciso) iso[r_d] = 1'b0;
      end
    end
    if (c >= r_cd) on[r_d] = r_tmo ? 1'b0 : r_on;
    dn = (c == r_cd);
    return {(c >= r_cd), dn && r_tmo, dn, on, psw, iso};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Per-cycle compare against the model, then drive the switch acknowledge.
  always @(posedge clk) begin : cmp_proc
    logic [14:0] e, a;
    logic [3:0]  ack;
    #1;
    if (rst) begin
      for (int k = 0; k < 16; k++) hist[k] = 4'hF;
      psw_ack = 4'hF;
    end else begin
      c_rel = c_rel + 1;
      e = exp_at(c_rel);
      if (chk_en) begin
        a = {req_ready, err, done, dom_on, psw_ctrl, iso_ctrl};
        n_chk++;
        if (a !== e) begin
          n_err++;
          $display("FAIL cycle_cmp c=%0d: got rdy/err/done/on/psw/iso=%b expected %b", c_rel, a, e);
        end
      end
      for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = e[7:4];
      ack = hist[g_lag];
      if (r_active && r_stuck && !r_noop && c_rel < r_cd) ack[r_d] = ~r_on;
      psw_ack = ack;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // noise: 0 quiet, 1 random requests while busy, 2 request held high while busy
  task automatic run_req(input logic [1:0] d, input logic on, input int lag, input logic stuck,
                         input int noise, input int rst_at);
    logic [14:0] s_e;
    int          need;
    @(posedge clk); #3;
    s_e   = exp_at(c_rel);
    b_iso = s_e[3:0]; b_psw = s_e[7:4]; b_on = s_e[11:8];
    r_d = d; r_on = on; r_stuck = stuck; r_noop = (on == b_on[d]);
    need  = (P > lag + 2) ? P : lag + 2;
    r_tmo = !r_noop && (stuck || need > T);
    if (r_noop) begin
      r_s = 0; r_ciso = 0; r_cd = 1;
    end else if (!on) begin
      r_s = 1 + I; r_ciso = 0; r_cd = r_tmo ? r_s + T : r_s + need;
    end else begin
      r_s = 1; r_ciso = r_s + need; r_cd = r_tmo ? r_s + T : r_ciso + I;
    end
    r_active = 1'b1; c_rel = -1; g_lag = lag;
    req_valid = 1'b1; req_dom = d; req_on = on;
    for (int c = 0; c < r_cd; c++) begin
      @(posedge clk); #3;
      if (rst_at > 0 && c == rst_at - 1) begin
        rst = 1'b1; r_active = 1'b0;
        b_iso = 4'h0; b_psw = 4'hF; b_on = 4'hF;
        @(posedge clk); #3;
        chk("rst_iso", {28'd0, iso_ctrl}, 32'h0);
        chk("rst_psw", {28'd0, psw_ctrl}, 32'hF);
        chk("rst_dom_on", {28'd0, dom_on}, 32'hF);
        chk("rst_no_done", {31'd0, done}, 32'd0);
        rst = 1'b0; req_valid = 1'b0;
        return;
      end
      if (noise == 2) begin
        req_valid = 1'b1; req_dom = 2'd0; req_on = 1'b0;
      end else if (noise == 1) begin
        req_valid = 1'($urandom_range(0, 1));
        req_dom = 2'($urandom_range(0, 3));
        req_on = 1'($urandom_range(0, 1));
      end else begin
        req_valid = 1'b0;
      end
    end
    @(posedge clk); #3;
    req_valid = 1'b0;
  endtask

  initial begin
    int lag;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3; rst = 1'b0; chk_en = 1'b1;
    @(posedge clk); #3;
    chk("reset_iso", {28'd0, iso_ctrl}, 32'h0);
    chk("reset_psw", {28'd0, psw_ctrl}, 32'hF);
    chk("reset_dom_on", {28'd0, dom_on}, 32'hF);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);

    run_req(2'd2, 1'b0, 1, 1'b0, 0, -1);
    chk("down_model_sw", r_s, 5);
    chk("down_model_done", r_cd, 13);
    chk("down_done", {31'd0, done}, 32'd1);
    chk("down_err", {31'd0, err}, 32'd0);
    chk("down_dom_on", {28'd0, dom_on}, 32'hB);
    idle(4);

    run_req(2'd2, 1'b1, 1, 1'b0, 0, -1);
    chk("up_model_iso", r_ciso, 9);
    chk("up_model_done", r_cd, 13);
    chk("up_done", {31'd0, done}, 32'd1);
    chk("up_dom_on", {28'd0, dom_on}, 32'hF);
    chk("up_iso", {28'd0, iso_ctrl}, 32'h0);
    idle(4);

    run_req(2'd0, 1'b1, 1, 1'b0, 1, -1);
    chk("noop_model_done", r_cd, 1);
    chk("noop_done", {31'd0, done}, 32'd1);
    chk("noop_err", {31'd0, err}, 32'd0);
    chk("noop_outs", {20'd0, dom_on, psw_ctrl, iso_ctrl}, 32'hFF0);
    idle(4);

    run_req(2'd1, 1'b0, 1, 1'b0, 0, -1);
    idle(4);
    run_req(2'd1, 1'b1, 1, 1'b1, 0, -1);
    chk("tmo_model_done", r_cd, 33);
    chk("tmo_done_err", {30'd0, done, err}, 32'd3);
    chk("tmo_psw1", {31'd0, psw_ctrl[1]}, 32'd0);
    chk("tmo_iso1", {31'd0, iso_ctrl[1]}, 32'd1);
    chk("tmo_dom_on1", {31'd0, dom_on[1]}, 32'd0);
    idle(4);

    run_req(2'd3, 1'b0, 1, 1'b0, 2, 6);
    idle(6);

    for (int i = 0; i < 40; i++) begin
      lag = $urandom_range(1, 12);
      run_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lag,
              ($urandom_range(0, 7) == 0), $urandom_range(0, 1), -1);
      idle(lag + 2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pwr_seq_ctrl.md
PWR_SEQ_CTRL -- requirements
Module: pwr_seq_ctrl

Interface
REQ-001 Parameter ISO_DLY, default 4, cycles that isolation is held before or after a power-switch change (≥1).
REQ-002 Parameter PSW_DLY, default 8, minimum cycles for the power switch to settle (≥1).
REQ-003 Parameter TIMEOUT, default 32, maximum cycles to wait for switch acknowledge (≥PSW_DLY).
REQ-004 Parameter RESET_ON, default 4'hF, per-domain powered state after reset.
REQ-005 clk  in  1  sole clock; all logic is rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  power-transition request valid.
REQ-008 req_ready  out  1  controller can accept a request.
REQ-009 req_dom  in  2  target domain index 0..3.
REQ-010 req_on  in  1  1 = power up, 0 = power down.
REQ-011 psw_ack  in  4  per-domain switch status from the power switches (1 = rail up).
REQ-012 iso_ctrl  out  4  per-domain isolation enable (1 = isolated); drives the ALU iso_ctrl.
REQ-013 psw_ctrl  out  4  per-domain switch enable (1 = powered); drives the ALU psw_ctrl.
REQ-014 dom_on  out  4  committed per-domain powered status.
REQ-015 done  out  1  one-cycle pulse marking completion of an accepted request.
REQ-016 err  out  1  one-cycle pulse, coincident with done, on acknowledge timeout.

Function
REQ-017 A request is accepted on a clock edge where req_valid and req_ready are both 1; req_dom and req_on are captured on that edge.
REQ-018 req_ready = 1 only in IDLE; requests presented outside IDLE are ignored, not queued.
REQ-019 FSM states are IDLE, ISO_SET, PSW_CLR, PSW_SET, ISO_CLR and DONE; exactly one request is in flight at a time.
REQ-020 No-op request (req_on equals dom_on[req_dom]): IDLE→DONE; done pulses the cycle after acceptance; no output changes.
REQ-021 Power-down path: IDLE→ISO_SET, with iso_ctrl[d]=1 from the next edge, held ISO_DLY cycles; then →PSW_CLR with psw_ctrl[d]=0.
REQ-022 Power-up path: IDLE→PSW_SET, with psw_ctrl[d]=1 from the next edge; then →ISO_CLR with iso_ctrl[d]=0, held ISO_DLY cycles; then →DONE.
REQ-023 PSW_CLR and PSW_SET exit only when at least PSW_DLY cycles have elapsed in the state and psw_ack[d]==psw_ctrl[d].
REQ-024 If the PSW_CLR/PSW_SET exit condition is not met after TIMEOUT cycles in the state: →DONE, err=1.
REQ-025 On power-up timeout: psw_ctrl[d] reverts to 0 and iso_ctrl[d] stays 1.
REQ-026 On any timeout: dom_on[d]=0.
REQ-027 dom_on[d] updates on entry to DONE: to req_on on success, to 0 on timeout.
REQ-028 DONE lasts one cycle, then →IDLE; req_ready=0 in DONE.
REQ-029 Success latency from acceptance to done is 1+ISO_DLY+PSW_DLY cycles when psw_ack is timely.
REQ-030 Bits of iso_ctrl, psw_ctrl and dom_on for non-target domains never change during a request.
REQ-031 All outputs are registered; iso_ctrl[d]=1 whenever psw_ctrl[d]=0 outside transitions.

Reset
REQ-032 On rst: state=IDLE, delay counter=0, iso_ctrl=~RESET_ON, psw_ctrl=RESET_ON, dom_on=RESET_ON, done=0, err=0, req_ready=1 on the following cycle.
REQ-033 rst asserted mid-transition abandons the request and applies the REQ-032 values on the next edge; no done pulse is issued.

Structure
REQ-034 A shared package pwr_seq_pkg holds the FSM state enum, the domain count (4) and the default delay constants.
REQ-035 One sub-module, pwr_dly_cnt, is used: a loadable down-counter with expired flag, shared by ISO/PSW hold timing and timeout.

Verification (ISO_DLY=4, PSW_DLY=8, TIMEOUT=32; cycle 0 = acceptance edge)
REQ-036 Reset: after release, require iso_ctrl=4'h0, psw_ctrl=4'hF, dom_on=4'hF and req_ready=1.
REQ-037 Power down dom 2, psw_ack follows psw_ctrl by 1 cycle: require iso_ctrl[2]↑ at 1, psw_ctrl[2]↓ at 5, done at 13 and dom_on=4'b1011.
REQ-038 Then power up dom 2, same ack model: require psw_ctrl[2]↑ at 1, iso_ctrl[2]↓ at 9, done at 13 and dom_on=4'hF.
REQ-039 Request power up of dom 0 while it is on: require done at 1, err=0 and no output change.
REQ-040 Power up dom 1 after power down, with psw_ack[1] stuck 0: require done=err=1 at 33, psw_ctrl[1]=0, iso_ctrl[1]=1 and dom_on[1]=0.
REQ-041 rst at cycle 6 of a dom 3 power down: require REQ-032 values on the next cycle and no done; req_valid held high in ISO_SET is not accepted.
